// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the N-channel register-file write-back arbiter.
package wb_arbiter_pkg;

  localparam int unsigned WbNchMax = 8;
  localparam int unsigned RegAddrW = 5;
  localparam logic [RegAddrW-1:0] ZeroReg = 5'd0;

  // Match counts only need to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'd2) ? c : c + 2'd1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for one write-back channel; also exposes every slot and its
// occupancy so the pending-rd scoreboard can search the queued entries.
module wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       din_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [Width-1:0]       head_o,
  output logic [Depth*Width-1:0] entries_o,
  output logic [Depth-1:0]       valid_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d, count;
  logic [AW-1:0]    offs;
  logic [Width-1:0] mem_q [Depth];

  // Extra pointer MSB separates the full and empty cases when the low bits match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q + {{AW{1'b0}}, push_i};
    rd_d  = rd_q + {{AW{1'b0}}, pop_i};
    count = wr_q - rd_q;
    offs  = '0;
    for (int j = 0; j < Depth; j++) begin
      offs = AW'(j) - rd_q[AW-1:0];
      valid_o[j] = ({1'b0, offs} < count);
      entries_o[j*Width +: Width] = mem_q[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// N-channel write-back stage: per-channel FIFOs drained round-robin into one REGS port,
// plus a pending-rd scoreboard. Define WB_FWD_EN to add single-match forwarding ports.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NCH-1:0]          i_wb_valid,
  input  logic [NCH*RegAddrW-1:0] i_wb_addr,
  input  logic [NCH*DW-1:0]       i_wb_data,
  output logic [NCH-1:0]          o_wb_ready,
  output logic                    o_rd_we,
  output logic [RegAddrW-1:0]     o_rd_waddr,
  output logic [DW-1:0]           o_rd_wdata,
  input  logic [RegAddrW-1:0]     i_rs1_addr,
  input  logic [RegAddrW-1:0]     i_rs2_addr,
  output logic                    o_rs1_pend,
  output logic                    o_rs2_pend,
`ifdef WB_FWD_EN
  output logic                    o_rs1_fwd_vld,
  output logic                    o_rs2_fwd_vld,
  output logic [DW-1:0]           o_rs1_fwd_data,
  output logic [DW-1:0]           o_rs2_fwd_data,
`endif
  output logic                    o_busy
);

  localparam int unsigned EW  = RegAddrW + DW;
  localparam int unsigned RrW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]         full, empty, push, pop;
  logic [EW-1:0]          head [NCH];
  logic [DEPTH*EW-1:0]    entries [NCH];
  logic [DEPTH-1:0]       evalid [NCH];
  logic [RrW-1:0]         rr_q, rr_d, gnt;
  logic                   gnt_vld;
  logic [EW-1:0]          gnt_head, ent;
  logic [1:0]             m1, m2;
  logic [DW-1:0]          fwd1_d, fwd2_d;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // x0 writes complete the handshake but are dropped here.
    assign push[g] = i_wb_valid[g] && !full[g] && (i_wb_addr[RegAddrW*g +: RegAddrW] != ZeroReg);

    wb_fifo #(
      .Depth (DEPTH),
      .Width (EW)
    ) u_fifo (
      .clk_i     (i_clk),
      .rst_ni    (i_rst_n),
      .push_i    (push[g]),
      .din_i     ({i_wb_addr[RegAddrW*g +: RegAddrW], i_wb_data[DW*g +: DW]}),
      .pop_i     (pop[g]),
      .full_o    (full[g]),
      .empty_o   (empty[g]),
      .head_o    (head[g]),
      .entries_o (entries[g]),
      .valid_o   (evalid[g])
    );
  end

  assign o_wb_ready = ~full | {NCH{~i_rst_n}};
  assign o_busy     = i_rst_n && (|(~empty));

  always_comb begin
    gnt_vld  = 1'b0;
    gnt      = '0;
    for (int k = 0; k < NCH; k++) begin
      int unsigned idx;
      idx = (int'(rr_q) + k) % NCH;
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = RrW'(idx);
      end
    end
    pop = '0;
    if (gnt_vld) pop[gnt] = 1'b1;
    rr_d = rr_q;
    if (gnt_vld) rr_d = (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
    gnt_head = '0;
    if (gnt_vld && i_rst_n) gnt_head = head[gnt];
  end

  assign o_rd_we    = gnt_vld && i_rst_n;
  assign o_rd_waddr = gnt_head[EW-1 -: RegAddrW];
  assign o_rd_wdata = gnt_head[DW-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) rr_q <= '0;
    else          rr_q <= rr_d;
  end

  // Saturating match counts over every stored entry, including the head being written now.
  always_comb begin
    m1     = '0;
    m2     = '0;
    fwd1_d = '0;
    fwd2_d = '0;
    ent    = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int e = 0; e < DEPTH; e++) begin
        ent = entries[c][e*EW +: EW];
        if (evalid[c][e] && i_rs1_addr != ZeroReg && ent[EW-1 -: RegAddrW] == i_rs1_addr) begin
          if (m1 == 2'd0) fwd1_d = ent[DW-1:0];
          m1 = sat_inc2(m1);
        end
        if (evalid[c][e] && i_rs2_addr != ZeroReg && ent[EW-1 -: RegAddrW] == i_rs2_addr) begin
          if (m2 == 2'd0) fwd2_d = ent[DW-1:0];
          m2 = sat_inc2(m2);
        end
      end
    end
    if (!i_rst_n) begin
      m1 = '0;
      m2 = '0;
    end
  end

`ifdef WB_FWD_EN
  assign o_rs1_pend     = (m1 == 2'd2);
  assign o_rs2_pend     = (m2 == 2'd2);
  assign o_rs1_fwd_vld  = (m1 == 2'd1);
  assign o_rs2_fwd_vld  = (m2 == 2'd1);
  assign o_rs1_fwd_data = (m1 == 2'd1) ? fwd1_d : '0;
  assign o_rs2_fwd_data = (m2 == 2'd1) ? fwd2_d : '0;
`else
  assign o_rs1_pend = (m1 != 2'd0);
  assign o_rs2_pend = (m2 != 2'd0);
  logic unused_fwd_data;
  assign unused_fwd_data = ^{fwd1_d, fwd2_d};
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NCH=2, DEPTH=2, DW=32); checks outputs #1 after each edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valid;
  logic [9:0]  addr;
  logic [63:0] data;
  logic [1:0]  ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  rs1, rs2;
  logic        pend1, pend2, busy;
`ifdef WB_FWD_EN
  logic        fv1, fv2;
  logic [31:0] fd1, fd2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NCH   (2),
    .DEPTH (2),
    .DW    (32)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wb_valid     (valid),
    .i_wb_addr      (addr),
    .i_wb_data      (data),
    .o_wb_ready     (ready),
    .o_rd_we        (we),
    .o_rd_waddr     (waddr),
    .o_rd_wdata     (wdata),
    .i_rs1_addr     (rs1),
    .i_rs2_addr     (rs2),
    .o_rs1_pend     (pend1),
    .o_rs2_pend     (pend2),
`ifdef WB_FWD_EN
    .o_rs1_fwd_vld  (fv1),
    .o_rs2_fwd_vld  (fv2),
    .o_rs1_fwd_data (fd1),
    .o_rs2_fwd_data (fd2),
`endif
    .o_busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1);
    valid = v;
    addr  = {a1, a0};
    data  = {d1, d0};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rs1   = 5'd0;
    rs2   = 5'd0;
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("rst_ready_in_reset", ready, 2'b11);
    chk("rst_we_in_reset", we, 1'b0);
    tick();
    rst_n = 1'b1;
    chk("idle_we", we, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", ready, 2'b11);
    chk("idle_waddr", waddr, 5'd0);
    chk("idle_wdata", wdata, 32'h0);
    chk("idle_pend", {pend1, pend2}, 2'b00);

    // Single push: visible on the write port the cycle after the push edge.
    drv(2'b01, 5'd5, 5'd0, 32'h11, 32'h0);
    tick();
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("t1_we", we, 1'b1);
    chk("t1_waddr", waddr, 5'd5);
    chk("t1_wdata", wdata, 32'h11);
    chk("t1_busy", busy, 1'b1);
    tick();
    chk("t1_we_after", we, 1'b0);
    chk("t1_busy_after", busy, 1'b0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Both channels at once from rr=0: ch0 then ch1.
    drv(2'b11, 5'd3, 5'd4, 32'hA, 32'hB);
    tick();
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("t2_first_waddr", waddr, 5'd3);
    chk("t2_first_wdata", wdata, 32'hA);
    tick();
    chk("t2_second_waddr", waddr, 5'd4);
    chk("t2_second_wdata", wdata, 32'hB);
    tick();
    chk("t2_idle_we", we, 1'b0);
    // rr must be back at 0, so ch0 wins again.
    drv(2'b11, 5'd1, 5'd2, 32'hC, 32'hD);
    tick();
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("t2_rr0_waddr", waddr, 5'd1);
    tick();
    chk("t2_rr1_waddr", waddr, 5'd2);
    tick();

    // ch1 fills while ch0 streams; blocked pushes must not be stored.
    drv(2'b11, 5'd10, 5'd20, 32'h100, 32'h200);
    tick();
    chk("t3_e1_waddr", waddr, 5'd10);
    drv(2'b11, 5'd11, 5'd21, 32'h101, 32'h201);
    tick();
    chk("t3_e2_ready", ready, 2'b01);
    chk("t3_e2_waddr", waddr, 5'd20);
    chk("t3_e2_wdata", wdata, 32'h200);
    drv(2'b11, 5'd12, 5'd22, 32'h102, 32'h202);
    tick();
    chk("t3_e3_waddr", waddr, 5'd11);
    chk("t3_e3_ready", ready, 2'b10);
    drv(2'b01, 5'd13, 5'd0, 32'h103, 32'h0);
    tick();
    chk("t3_e4_waddr", waddr, 5'd21);
    chk("t3_e4_ready", ready, 2'b11);
    tick();
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("t3_e5_waddr", waddr, 5'd12);
    chk("t3_e5_wdata", wdata, 32'h102);
    tick();
    chk("t3_e6_waddr", waddr, 5'd13);
    chk("t3_e6_wdata", wdata, 32'h103);
    tick();
    chk("t3_drained_we", we, 1'b0);
    chk("t3_drained_busy", busy, 1'b0);

    // x0 write is accepted and dropped.
    drv(2'b01, 5'd0, 5'd0, 32'hFF, 32'h0);
    chk("t4_x0_ready", ready[0], 1'b1);
    tick();
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("t4_x0_we", we, 1'b0);
    chk("t4_x0_busy", busy, 1'b0);

    rs1 = 5'd7;
    drv(2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
    chk("t4_pend_before_push", pend1, 1'b0);
    tick();
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("t4_waddr", waddr, 5'd7);
`ifdef WB_FWD_EN
    chk("t4_pend1", pend1, 1'b0);
    chk("t4_fwd_vld", fv1, 1'b1);
    chk("t4_fwd_data", fd1, 32'h77);
`else
    chk("t4_pend1", pend1, 1'b1);
`endif
    tick();
    chk("t4_pend1_cleared", pend1, 1'b0);

    // rd=9 queued twice; then reset discards both.
    rs2 = 5'd9;
    drv(2'b11, 5'd9, 5'd9, 32'h90, 32'h91);
    tick();
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("t5_pend2", pend2, 1'b1);
    chk("t5_pend1_other", pend1, 1'b0);
`ifdef WB_FWD_EN
    chk("t5_fwd2_vld", fv2, 1'b0);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_we", we, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_pend2", pend2, 1'b0);
    chk("t5_rst_ready", ready, 2'b11);
    tick();
    chk("t5_rst_we_next", we, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
